// File: rtl/bcd_xs3_stream_conv.sv
// Sequential BCD <-> Excess-3 converter: one 4-bit digit per clock, per-digit invalid flags.
// Accept-to-result latency is DIGITS cycles; the result is held until out_ready.
module bcd_xs3_stream_conv #(
  parameter int DIGITS = 4,
  localparam int W = 4 * DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [DIGITS-1:0] out_err,
  output logic              out_any_err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      opnd_q, opnd_d;
  logic              mode_q, mode_d;
  logic [W-1:0]      res_q, res_d;
  logic [DIGITS-1:0] err_q, err_d;
  logic [W-1:0]      dout_q, dout_d;
  logic [DIGITS-1:0] eout_q, eout_d;
  logic              rdy_q, vld_q;

  logic [3:0] cur_dig;
  logic [3:0] conv_dig;
  logic       bad_dig;

  always_comb begin
    cur_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_dig = opnd_q[4*i +: 4];
    end
    if (!mode_q) begin
      bad_dig  = (cur_dig > 4'd9);
      conv_dig = cur_dig + 4'd3;
    end else begin
      bad_dig  = (cur_dig < 4'd3) || (cur_dig > 4'd12);
      conv_dig = cur_dig - 4'd3;
    end
    if (bad_dig) conv_dig = 4'hF;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opnd_d  = opnd_q;
    mode_d  = mode_q;
    res_d   = res_q;
    err_d   = err_q;
    dout_d  = dout_q;
    eout_d  = eout_q;
    case (state_q)
      IDLE: begin
        // rdy_q gates acceptance so the first cycle after reset release is not an accept
        if (in_valid && rdy_q) begin
          opnd_d  = in_data;
          mode_d  = in_mode;
          res_d   = '0;
          err_d   = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) begin
            res_d[4*i +: 4] = conv_dig;
            err_d[i]        = bad_dig;
          end
        end
        if (idx_q == IW'(DIGITS - 1)) begin
          idx_d   = '0;
          dout_d  = res_d;
          eout_d  = err_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opnd_q  <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= '0;
      dout_q  <= '0;
      eout_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opnd_q  <= opnd_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      eout_q  <= eout_d;
      rdy_q   <= (state_d == IDLE);
      vld_q   <= (state_d == DONE);
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = vld_q;
  assign out_data    = dout_q;
  assign out_err     = eout_q;
  assign out_any_err = |eout_q;

endmodule

// File: tb/tb_bcd_xs3_stream_conv.sv
// Bench for bcd_xs3_stream_conv: DIGITS=4 directed plus DIGITS=1/4/8 random, all checked
// every cycle against a digit-arithmetic reference model.
module tb_bcd_xs3_stream_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_mode;
  logic        out_ready;
  logic [63:0] in_data64;

  logic        rdy4, vld4, any4;
  logic [15:0] dat4;
  logic [3:0]  err4;
  logic        rdy1, vld1, any1;
  logic [3:0]  dat1;
  logic [0:0]  err1;
  logic        rdy8, vld8, any8;
  logic [31:0] dat8;
  logic [7:0]  err8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_xs3_stream_conv #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data64[15:0]), .in_mode(in_mode), .out_valid(vld4),
    .out_ready(out_ready), .out_data(dat4), .out_err(err4), .out_any_err(any4));

  bcd_xs3_stream_conv #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data64[3:0]), .in_mode(in_mode), .out_valid(vld1),
    .out_ready(out_ready), .out_data(dat1), .out_err(err1), .out_any_err(any1));

  bcd_xs3_stream_conv #(.DIGITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data64[31:0]), .in_mode(in_mode), .out_valid(vld8),
    .out_ready(out_ready), .out_data(dat8), .out_err(err8), .out_any_err(any8));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: returns {err[63:0], data[63:0]} for the low n digits of d.
  function automatic logic [127:0] ref_conv(input logic [63:0] d, input logic m, input int n);
    logic [63:0] o, e;
    int v;
    o = '0;
    e = '0;
    for (int i = 0; i < n; i++) begin
      v = int'(d[4*i +: 4]);
      if (m == 1'b0 && v <= 9) o[4*i +: 4] = 4'(v + 3);
      else if (m == 1'b1 && v >= 3 && v <= 12) o[4*i +: 4] = 4'(v - 3);
      else begin
        o[4*i +: 4] = 4'hF;
        e[i] = 1'b1;
      end
    end
    return {e, o};
  endfunction

  // Per-instance expectation: 0 -> DIGITS=4, 1 -> DIGITS=1, 2 -> DIGITS=8
  logic        exp_rdy [3];
  logic        exp_vld [3];
  int          cnt     [3];
  logic [63:0] exp_dat [3];
  logic [63:0] exp_err [3];

  task automatic mon(input int k, input int n, input logic rdy, input logic vld,
                     input logic [63:0] dat, input logic [63:0] err, input logic any);
    logic [127:0] r;
    if (!rst_n) begin
      chk($sformatf("d%0d_rst_rdy", n), 64'(rdy), 64'd0);
      chk($sformatf("d%0d_rst_vld", n), 64'(vld), 64'd0);
      chk($sformatf("d%0d_rst_dat", n), dat, 64'd0);
      chk($sformatf("d%0d_rst_err", n), err | 64'(any), 64'd0);
      exp_rdy[k] = 1'b0;
      exp_vld[k] = 1'b0;
      cnt[k]     = 0;
      return;
    end
    chk($sformatf("d%0d_in_ready", n), 64'(rdy), 64'(exp_rdy[k]));
    chk($sformatf("d%0d_out_valid", n), 64'(vld), 64'(exp_vld[k]));
    if (exp_vld[k]) begin
      chk($sformatf("d%0d_out_data", n), dat, exp_dat[k]);
      chk($sformatf("d%0d_out_err", n), err, exp_err[k]);
      chk($sformatf("d%0d_out_any_err", n), 64'(any), 64'(|exp_err[k]));
    end
    // predict the effect of the coming rising edge
    if (exp_rdy[k] && in_valid) begin
      r = ref_conv(in_data64, in_mode, n);
      exp_dat[k] = r[63:0];
      exp_err[k] = r[127:64];
      exp_rdy[k] = 1'b0;
      cnt[k]     = n;
    end else if (cnt[k] > 0) begin
      cnt[k]--;
      if (cnt[k] == 0) exp_vld[k] = 1'b1;
    end else if (exp_vld[k] && out_ready) begin
      exp_vld[k] = 1'b0;
      exp_rdy[k] = 1'b1;
    end else if (!exp_vld[k] && !exp_rdy[k]) begin
      exp_rdy[k] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, rdy4, vld4, 64'(dat4), 64'(err4), any4);
    mon(1, 1, rdy1, vld1, 64'(dat1), 64'(err1), any1);
    mon(2, 8, rdy8, vld8, 64'(dat8), 64'(err8), any8);
  end

  // Drives one DIGITS=4 operand, checks latency and literal result, then completes the handshake.
  task automatic send(input logic [15:0] d, input logic m, input logic [15:0] ed,
                      input logic [3:0] ee, input int hold);
    int w, lat;
    in_valid  = 1'b1;
    in_data64 = {$urandom, $urandom};
    in_data64[15:0] = d;
    in_mode   = m;
    out_ready = (hold == 0);
    w = 0;
    while (!rdy4 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("accept_wait_bound", 64'(w < 50), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_mode   = ~m;
    in_data64 = {$urandom, $urandom};
    lat = 0;
    while (!vld4 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    chk("lit_out_data", 64'(dat4), 64'(ed));
    chk("lit_out_err", 64'(err4), 64'(ee));
    chk("lit_out_any_err", 64'(any4), 64'(|ee));
    if (hold > 0) begin
      repeat (hold) begin
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("hold_valid", 64'(vld4), 64'd1);
        chk("hold_in_ready", 64'(rdy4), 64'd0);
        chk("hold_data", 64'(dat4), 64'(ed));
        chk("hold_err", 64'(err4), 64'(ee));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_hs_valid", 64'(vld4), 64'd0);
    chk("post_hs_in_ready", 64'(rdy4), 64'd1);
    chk("post_hs_data_kept", 64'(dat4), 64'(ed));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    in_data64 = '0;

    r = ref_conv(64'h1234, 1'b0, 4);
    chk("model_bcd_1234", r[63:0], 64'h4567);
    r = ref_conv(64'h2D33, 1'b1, 4);
    chk("model_xs3_2D33", r[63:0], 64'hFF00);
    chk("model_xs3_2D33_err", r[127:64], 64'hC);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", 64'(rdy4), 64'd0);
    chk("reset_out_data", 64'(dat4), 64'd0);
    @(posedge clk); #1;
    chk("first_edge_in_ready", 64'(rdy4), 64'd1);

    send(16'h1234, 1'b0, 16'h4567, 4'b0000, 0);
    send(16'h0909, 1'b0, 16'h3C3C, 4'b0000, 0);
    send(16'h4567, 1'b1, 16'h1234, 4'b0000, 0);
    send(16'h3C3C, 1'b1, 16'h0909, 4'b0000, 0);
    send(16'h9A09, 1'b0, 16'hCF3C, 4'b0100, 0);
    send(16'h2D33, 1'b1, 16'hFF00, 4'b1100, 0);
    send(16'h8765, 1'b0, 16'hBA98, 4'b0000, 3);

    // asynchronous reset after two conversion cycles
    in_valid  = 1'b1;
    in_data64 = 64'h5555;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", 64'(rdy4), 64'd0);
    chk("async_rst_out_valid", 64'(vld4), 64'd0);
    chk("async_rst_out_data", 64'(dat4), 64'd0);
    chk("async_rst_out_err", 64'({any4, err4}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("after_rst_no_valid", 64'(vld4), 64'd0);
    send(16'h0000, 1'b0, 16'h3333, 4'b0000, 0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_mode   = ($urandom_range(0, 1) == 1);
      in_data64 = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_xs3_stream_conv.md
Name: bcd_xs3_stream_conv

Overview:
- Multi-digit, bidirectional converter between packed BCD and Excess-3 (XS3) code.
- Processes one 4-bit digit per clock and flags invalid digits per digit.
- Valid/ready handshakes on both input and output.
- Sits between the digit-entry/arith front end and display/decimal-adder logic; this is the parametrised, sequential successor of the single-digit combinational BCD-to-XS3 converter.

Parameters:
- DIGITS, 4, number of 4-bit digits per operand (1..16); data width W = 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  converter can accept an operand
- in_data  input  W  packed operand; digit i = bits [4i+3:4i]
- in_mode  input  1  0 = BCD to XS3, 1 = XS3 to BCD
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  W  packed converted result
- out_err  output  DIGITS  per-digit invalid flag, bit i for digit i
- out_any_err  output  1  OR of out_err

Behaviour:
- Reset is asynchronous on rst_n low. All outputs go to 0: in_ready=0, out_valid=0, out_data=0, out_err=0, out_any_err=0. State = IDLE, idx = 0.
- The internal operand and mode registers also clear on reset.
- in_ready goes to 1 on the first clk edge after rst_n deasserts, i.e. once registered IDLE is entered.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture in_data and in_mode into internal registers, clear result and err, set idx=0, go to CONV.
  - in_data and in_mode are ignored at all other times. Mode is latched per operand.
- CONV: in_ready=0. Each cycle converts digit idx, writes it into result slot idx, sets err[idx] if invalid, then increments idx.
  - When the digit just converted is idx == DIGITS-1, go to DONE.
- Digit rules:
  - Mode 0: valid digits 0..9; out = d + 3 (4-bit).
  - Mode 1: valid digits 3..12; out = d - 3 (4-bit).
  - An invalid digit produces output 4'b1111 and sets its err bit. Conversion continues with the remaining digits; there is no early abort.
- DONE: out_valid=1.
  - out_data, out_err and out_any_err are stable while out_valid=1 && out_ready=0.
  - On out_ready: go to IDLE; out_valid drops on the next edge.
  - out_data and out_err keep their last values after the handshake until the next result is written.
- Latency: accept on edge E gives out_valid=1 after edge E+DIGITS. There is at least one idle cycle between results (in_ready rises the edge after output handshake).
- DIGITS=1: exactly one CONV cycle.
- idx width is clog2(DIGITS), minimum 1. No wrap beyond DIGITS-1.
- Reset mid-CONV or mid-DONE discards the operation; outputs return to reset values immediately.
- out_ready asserted outside DONE has no effect. in_valid held high while busy is not accepted.

Test Plan:
- DIGITS=4, mode 0, in_data=16'h1234, out_ready=1 → out_valid after exactly 4 cycles, out_data=16'h4567, out_err=0; also check 16'h0909 → 16'h3C3C.
- Mode 1, in_data=16'h4567, then 16'h3C3C → out_data=16'h1234, then 16'h0909; no errors; mode taken at accept even if in_mode toggles during CONV.
- Invalid digits: mode 0, in_data=16'h9A09 → out_data=16'hCF3C, out_err=4'b0100, out_any_err=1. Mode 1, in_data=16'h2D33 → out_data=16'hFF00, out_err=4'b1100.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_data/out_err stable, in_ready=0, second in_valid not accepted. Release → out_valid drops, in_ready=1 the next cycle.
- Reset: pull rst_n low asynchronously after 2 CONV cycles → all outputs 0 immediately, no out_valid after release. A new operand 16'h0000 mode 0 then yields 16'h3333.
- Parameter sweep: DIGITS=1 and DIGITS=8 with random valid/invalid digits against a reference model → latency = DIGITS and bit-exact data/err.
